gc_table_serializer: RTL

GC_TABLE_SERIALIZER -- requirements
Module: gc_table_serializer

---
 rtl/gc_table_serializer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gc_table_serializer.sv
// rtl/gc_table_serializer.sv - buffers garbled gate tables and streams them out as W-bit words
// A DEPTH-entry FIFO of {gid, t0, t1}; the head entry is sliced into 2K/W words, t0 first, LSW first.

module gc_table_serializer #(
    parameter int K     = 128,
    parameter int S     = 20,
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [S-1:0]               in_gid,
    input  logic [K-1:0]               in_t0,
    input  logic [K-1:0]               in_t1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [S-1:0]               out_gid,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                table_cnt
);

    localparam int N  = 2 * K / W;
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int XW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [2*K-1:0]    mem_tab [DEPTH];
    logic [S-1:0]      mem_gid [DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [XW-1:0]     widx;

    logic              in_xfer;
    logic              out_xfer;
    logic              last_word;
    logic              pop;

    logic [2*K-1:0]    head_tab;
    logic [W-1:0]      words [N];

    assign in_ready  = (occupancy < OW'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_word = (widx == XW'(N - 1));
    assign pop       = out_xfer && last_word;
    assign out_last  = out_valid && last_word;

    // Storage is written without reset; its contents only matter while out_valid is high.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem_tab[tail] <= {in_t1, in_t0};
            mem_gid[tail] <= in_gid;
        end
    end

    assign head_tab = mem_tab[head];
    assign out_gid  = mem_gid[head];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            words[i] = head_tab[i*W +: W];
        end
    end

    assign out_data = words[widx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                // Only the final word of the only entry, with nothing arriving, empties the buffer.
                if (pop && (occupancy == OW'(1)) && !in_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            widx      <= '0;
            occupancy <= '0;
            table_cnt <= '0;
        end else begin
            if (in_xfer) begin
                tail <= tail + PW'(1);
            end
            if (out_xfer) begin
                widx <= last_word ? '0 : widx + XW'(1);
            end
            if (pop) begin
                head      <= head + PW'(1);
                table_cnt <= table_cnt + 32'd1;
            end
            case ({in_xfer, pop})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
